// File: rtl/ysyx_23060136_ifu_fetch.sv
// Instruction fetch front end: issues one I-cache request per committed PC and hands the instruction to IDU.
// Latency: capture -> request next cycle; with ready and response each on their first cycle, IFU_valid 3 cycles after capture.
// Backpressure: request held stable until icache_req_ready; result held in HOLD while FORWARD_stallIF; flush kills in-flight work.
//
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   BRANCH_flushIF, BHT_flushIF       - redirect (either one flushes)
//   FORWARD_stallIF                   - IDU cannot take the held instruction
//   IFU2_pc, IFU2_commit              - next PC to fetch and its valid
//   icache_req_valid/addr/ready       - I-cache request handshake
//   icache_rsp_valid/inst/err         - single-beat I-cache response
//   IFU_pc/inst/valid/fault           - fetched instruction to IDU
//   IFU_busy                          - a request is outstanding
module ysyx_23060136_ifu_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        BRANCH_flushIF,
    input  logic        BHT_flushIF,
    input  logic        FORWARD_stallIF,
    input  logic [31:0] IFU2_pc,
    input  logic        IFU2_commit,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_rsp_valid,
    input  logic [31:0] icache_rsp_inst,
    input  logic        icache_rsp_err,
    output logic [31:0] IFU_pc,
    output logic [31:0] IFU_inst,
    output logic        IFU_valid,
    output logic        IFU_fault,
    output logic        IFU_busy
);

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // KILL: request still presented but its result is doomed.
    // DRAIN: request accepted, waiting only to swallow the response.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_KILL,
        S_DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_fault;
    logic        w_flush;
    logic        w_capture;
    logic        w_latch;

    assign w_flush = BRANCH_flushIF | BHT_flushIF;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (IFU2_commit && !w_flush) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (icache_req_ready) begin
                    w_state_nxt = w_flush ? S_DRAIN : S_WAIT;
                end else if (w_flush) begin
                    w_state_nxt = S_KILL;
                end
            end
            S_KILL: begin
                // The request cannot be withdrawn; wait for acceptance, then swallow the response.
                if (icache_req_ready) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_WAIT: begin
                if (icache_rsp_valid) begin
                    if (w_flush) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (w_flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (icache_rsp_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (w_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (!FORWARD_stallIF) begin
                    if (IFU2_commit) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One address register serves both the request and the PC reported with the result;
    // it only changes on capture, so it is stable throughout REQ/KILL/WAIT/HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= RESET_PC;
            r_inst  <= NOP_INST;
            r_fault <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr <= IFU2_pc;
            end
            if (w_latch) begin
                r_inst  <= icache_rsp_err ? NOP_INST : icache_rsp_inst;
                r_fault <= icache_rsp_err;
            end
        end
    end

    // All outputs come from registers or state decode only.
    assign icache_req_valid = (r_state == S_REQ) || (r_state == S_KILL);
    assign icache_req_addr  = r_addr;
    assign IFU_pc           = r_addr;
    assign IFU_inst         = r_inst;
    assign IFU_fault        = r_fault;
    assign IFU_valid        = (r_state == S_HOLD);
    assign IFU_busy         = (r_state == S_REQ) || (r_state == S_KILL) ||
                              (r_state == S_WAIT) || (r_state == S_DRAIN);

endmodule

// File: doc/ysyx_23060136_ifu_fetch.md
YSYX_23060136_IFU_FETCH -- requirements
Module: ysyx_23060136_ifu_fetch

Interface
REQ-001 SHALL have port clk, input, 1 -- single clock; all state on posedge.
REQ-002 SHALL have port rst, input, 1 -- reset, asynchronous, active-low.
REQ-003 SHALL have inputs BRANCH_flushIF and BHT_flushIF, 1 each -- redirect; flush = BRANCH_flushIF | BHT_flushIF.
REQ-004 SHALL have input FORWARD_stallIF, 1 -- downstream (IDU) not ready to consume.
REQ-005 SHALL have input IFU2_pc, 32 -- PC from the IF mini-pipeline segment.
REQ-006 SHALL have input IFU2_commit, 1 -- IFU2_pc is valid.
REQ-007 SHALL have outputs icache_req_valid (1) and icache_req_addr (32) -- I-cache request.
REQ-008 SHALL have input icache_req_ready, 1 -- request accepted when valid & ready.
REQ-009 SHALL have inputs icache_rsp_valid (1), icache_rsp_inst (32) and icache_rsp_err (1) -- single-beat response.
REQ-010 SHALL have outputs IFU_pc (32), IFU_inst (32), IFU_valid (1) and IFU_fault (1) -- to IDU.
REQ-011 SHALL have output IFU_busy, 1 -- request in flight, ORed into the IF stall by the hazard unit.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, KILL, DRAIN, with all outputs registered or decoded from state only (no input-to-output combinational path).
REQ-013 IDLE: IFU2_commit & ~flush SHALL capture IFU2_pc into the address register -> REQ; this capture does not depend on FORWARD_stallIF.
REQ-014 REQ: icache_req_valid=1, addr=captured PC, held stable until accepted; ready & ~flush -> WAIT; ready & flush -> DRAIN; ~ready & flush -> KILL.
REQ-015 KILL: icache_req_valid stays 1 with the same address (no request withdrawal); on ready -> DRAIN.
REQ-016 WAIT: rsp_valid & ~flush SHALL latch IFU_inst=rsp_inst and IFU_fault=rsp_err -> HOLD; rsp_valid & flush -> IDLE, response discarded; ~rsp_valid & flush -> DRAIN.
REQ-017 DRAIN: on rsp_valid, response discarded -> IDLE; further flushes have no effect.
REQ-018 On rsp_err=1 the latched IFU_inst SHALL be 32'h0000_0013 (NOP) and IFU_fault=1.
REQ-019 HOLD: IFU_valid=1, with IFU_pc/IFU_inst/IFU_fault stable.
- flush -> IDLE, IFU_valid=0 next cycle.
- ~FORWARD_stallIF & IFU2_commit -> capture IFU2_pc -> REQ.
- ~FORWARD_stallIF & ~IFU2_commit -> IDLE.
- FORWARD_stallIF -> remain in HOLD.
REQ-020 IFU_valid SHALL be 1 only in HOLD; IFU_busy SHALL be 1 exactly in REQ, KILL, WAIT and DRAIN.
REQ-021 Responses in IDLE, REQ, KILL or HOLD SHALL be ignored; at most one request is outstanding.
REQ-022 Minimum latency: capture edge T, req_valid at T+1, ready at T+1 -> WAIT at T+2, rsp at T+2 -> IFU_valid=1 at T+3.
REQ-023 Flush SHALL take priority over every other same-cycle event in every state.

Reset
REQ-024 While rst=0, outputs SHALL asynchronously be: state IDLE, icache_req_valid=0, icache_req_addr=32'h8000_0000, IFU_pc=32'h8000_0000, IFU_inst=32'h0000_0013, IFU_valid=0, IFU_fault=0, IFU_busy=0.
REQ-025 Reset asserted mid-transaction SHALL drop the transaction; a response arriving after reset release while in IDLE is ignored.

Verification
REQ-026 Basic fetch: commit=1, pc=0x80000004, ready=1 at T+1, rsp inst=0x00100093 at T+2 -> IFU_valid=1, IFU_pc=0x80000004, IFU_inst=0x00100093 at T+3.
REQ-027 Backpressure: ready=0 for 3 cycles -> req_valid/addr stable, IFU_busy=1; FORWARD_stallIF=1 in HOLD for 4 cycles -> outputs unchanged.
REQ-028 Flush in WAIT: flush with no response, response 2 cycles later -> DRAIN, response discarded, IFU_valid stays 0, IDLE after the response.
REQ-029 Flush in REQ while ready=0 -> KILL, req held until ready, then DRAIN, response dropped; flush with ready=1 -> DRAIN directly.
REQ-030 Error response: rsp_err=1 -> IFU_inst=0x00000013, IFU_fault=1, IFU_valid=1.
REQ-031 Async reset asserted mid-WAIT, response while in reset and a stray response after release -> all REQ-024 values, IFU_valid never asserted.
